ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
Upstream feeder of the keyboard matrix. It receives the raw PS/2 clock/data pair from the keyboard connector, deserialises 11-bit frames and folds the E0/F0/E1 prefixes. It emits the 11-bit ps2_key event word that the matrix and system top consume on clk_sys. The block is receive-only; it never drives the PS/2 lines.

Parameters:
FILTER_LEN, 8, consecutive equal clk_sys samples required before the filtered ps2_clk changes level.
TIMEOUT_CYCLES, 26000, clk_sys cycles with no filtered falling edge before a partial frame is aborted (2 ms at 13 MHz).

Ports:
clk_sys  in  1  system clock (13 MHz).
reset_n  in  1  asynchronous active-low reset.
ps2_clk  in  1  raw PS/2 clock, asynchronous.
ps2_data  in  1  raw PS/2 data, asynchronous.
ps2_key  out  11  event word: [10] toggles per event, [9] pressed (1=make, 0=break), [8] extended (E0), [7:0] scancode.
frame_err  out  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

Behaviour:
- Clocking and reset: one clock, clk_sys. reset_n is asynchronous, active-low. All flops clear on reset: ps2_key=0, frame_err=0, FSM=IDLE, prefix flags=0, skip count=0.
- Input path: 2-flop synchroniser on both lines. Filter counter of width clog2(FILTER_LEN)+1. The filtered clock takes the synchronised value only after FILTER_LEN equal consecutive samples. The counter restarts on any mismatch.
- Edge: fall = filtered clock 1->0, registered. Data is sampled on the synchronised ps2_data in the same cycle as fall.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE, pulse frame_err.
  - DATA: shift in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: accept the byte only if stop=1 and the XOR of 8 data bits plus parity = 1 (odd parity). Otherwise pulse frame_err and clear the prefix flags. Return to IDLE either way.
- Timeout: in any state other than IDLE, a counter increments each clk_sys and resets on fall. On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear prefix flags. No output change.
- Byte disposition, evaluated in the cycle after the accepted STOP edge:
  - Skip count > 0: decrement it, discard the byte.
  - E1: set skip count=7 (Pause sequence swallowed), discard.
  - E0: set ext flag, no output.
  - F0: set rel flag, no output.
  - FA, AA, EE, FE, 00, FF: discard, flags unchanged.
  - Any other byte: ps2_key <= {~ps2_key[10], ~rel, ext, byte}, then clear ext and rel.
- Latency: ps2_key updates exactly 2 clk_sys after the fall that samples the stop bit. It holds until the next event.
- Simultaneous events: reset dominates everything. A timeout and a fall in the same cycle: fall wins and the timeout counter clears.
- Reset mid-frame: the partial frame is discarded and no event is emitted.
- ps2_key[10] wraps by toggling. Consumers detect an event by comparing against a registered copy.

Decomposition:
- ps2_pkg: localparams for byte codes (PS2_EXT=E0, PS2_REL=F0, PS2_PAUSE=E1, ACK=FA, BAT=AA, ECHO=EE, RESEND=FE) and the FSM state encoding (IDLE, DATA, PARITY, STOP; 2 bits).
- One sub-module, ps2_line_filter: synchroniser plus glitch filter plus fall detect. Instanced once for the clock line; the data line uses its synchroniser only.

Test Plan:
- Frame 0x1C (A), parity 0, stop 1, bit period 80 us -> ps2_key=0x61C (bit10 set from reset 0), frame_err stays 0, update 2 clk_sys after the stop-bit fall.
- Frames F0 then 1C -> one event only, ps2_key[9:0]=0x01C, bit10 toggled again.
- Frames E0, F0, 75 -> ps2_key[9:0]=0x175. A following plain 75 gives [9:0]=0x275 (flags cleared).
- Frame 0x1C with parity forced to 1 -> frame_err one-cycle pulse, ps2_key unchanged. The next good 0x32 gives [9:0]=0x232.
- Start bit plus 4 data bits, then lines held high for 3 ms -> frame_err pulse at 2 ms, FSM back in IDLE. A following good 0x1C decodes correctly.
- Glitches: 3-cycle low pulses on ps2_clk inside bit periods -> ignored, decoded byte correct. Pause sequence E1 14 77 E1 F0 14 F0 77 -> no event. reset_n asserted mid-frame -> ps2_key=0 immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 byte codes, receiver state encoding and byte classification.
package ps2_pkg;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    function automatic logic is_discard(input logic [7:0] b);
        return b inside {PS2_ACK, PS2_BAT, PS2_ECHO, PS2_RESEND, 8'h00, 8'hFF};
    endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchroniser and glitch filter for the PS/2 clock line, with a registered falling-edge strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_fall
);
    localparam int CW = $clog2(FILTER_LEN) + 1;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    logic          r_fall;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_filt <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_fall <= 1'b0;
            // any sample agreeing with the current level restarts the run
            if (r_sync[1] == r_filt) r_cnt <= '0;
            else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
                r_fall <= r_filt;
            end else r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_fall = r_fall;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receive-only PS/2 deserialiser that folds E0/F0/E1 prefixes into an 11-bit key event word.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 26000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    ps2_state_e    r_state, w_state_nxt;
    logic [1:0]    r_data_sync;
    logic [2:0]    r_bit_cnt, r_skip;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
    logic [10:0]   r_key;
    logic          r_parity, r_accept, r_err, r_ext, r_rel;
    logic          w_fall, w_data, w_timeout, w_accept, w_err, w_clr;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .i_raw  (ps2_clk),
        .o_fall (w_fall)
    );

    assign w_data    = r_data_sync[1];
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_accept    = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (w_data) w_err = 1'b1; else w_state_nxt = ST_DATA;
                ST_DATA:   w_state_nxt = (r_bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_accept    = w_data && (^{r_shift, r_parity});
                    w_err       = !w_accept;
                end
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
        end
    end

    // a bad start bit is not a broken prefix sequence, so it keeps the flags
    assign w_clr = w_err && (r_state != ST_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_data_sync <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_accept    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_accept    <= w_accept;
            r_err       <= w_err;
            r_to_cnt    <= (w_fall || r_state == ST_IDLE || w_timeout) ? '0 : r_to_cnt + TW'(1);
            if (w_fall && r_state == ST_IDLE) r_bit_cnt <= '0;
            if (w_fall && r_state == ST_DATA) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_fall && r_state == ST_PARITY) r_parity <= w_data;
        end
    end

    // r_shift stays stable through IDLE, so it doubles as the accepted byte
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key  <= '0;
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= '0;
        end else if (w_clr) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
        end else if (r_accept) begin
            if (r_skip != 3'd0) r_skip <= r_skip - 3'd1;
            else if (r_shift == PS2_PAUSE) r_skip <= PAUSE_SKIP;
            else if (r_shift == PS2_EXT) r_ext <= 1'b1;
            else if (r_shift == PS2_REL) r_rel <= 1'b1;
            else if (!is_discard(r_shift)) begin
                r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign ps2_key   = r_key;
    assign frame_err = r_err;
endmodule
